sample_sequencer: RTL and testbench

Triangle-to-sample scheduler that sits directly in front of `sampletest`. It accepts one triangle and its bounding box from the upstream bounding-box stage. It then walks every sample-grid location inside the box in raster order and issues one sample per cycle, with the triangle and colour held alongside it. Upstream is throttled through a halt signal; downstream can pause issue with a hold input.

---
 rtl/sample_sequencer.sv | 152 +++++++++++++++
 tb/tb_sample_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - triangle-to-sample raster scheduler in front of sampletest
//
// Accepts one triangle plus its grid-snapped inclusive bounding box while idle,
// then walks every sample location of the box in raster order (x fastest, y
// ascending), one sample per cycle, with the captured triangle and colour held
// alongside it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tri_R13S          triangle vertices in  [VERTS][AXIS], signed
//   color_R13U        triangle colour in    [COLORS], unsigned
//   box_R13S          bounding box [0]=lower-left [1]=upper-right, [.][0]=x [.][1]=y
//   pitch_R13U        sample pitch (only with SUBSAMPLE_EN)
//   validTri_R13H     triangle/box valid
//   halt_R13H         high while walking; upstream must hold its inputs
//   hold_R16H         downstream pause, gates issue combinationally
//   tri_R16S          captured triangle, stable for the walk
//   color_R16U        captured colour, stable for the walk
//   sample_R16S       current sample (x,y)
//   validSamp_R16H    sample valid this cycle
//   last_R16H         final sample of the current triangle
//
// Optional feature macro: SUBSAMPLE_EN (programmable pitch; default is one
// sample per pixel and pitch_R13U is ignored).
module sample_sequencer #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R13U [COLORS],
   input  logic signed [SIGFIG-1:0] box_R13S [2][2],
   input  logic        [SIGFIG-1:0] pitch_R13U,
   input  logic                     validTri_R13H,
   output logic                     halt_R13H,
   input  logic                     hold_R16H,
   output logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R16U [COLORS],
   output logic signed [SIGFIG-1:0] sample_R16S [2],
   output logic                     validSamp_R16H,
   output logic                     last_R16H
);

   localparam logic [SIGFIG-1:0] PIX = SIGFIG'(1) << RADIX;

   typedef enum logic {IDLE, WALK} state_t;

   state_t                   state, state_nxt;
   logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y, cur_x, cur_y;
   logic        [SIGFIG-1:0] pitch_q, pitch_in;
   // One extra bit so cur+P near the top of the range cannot wrap negative.
   logic signed [SIGFIG:0]   nx_x, nx_y, ur_xw, ur_yw;
   logic                     x_fits, y_fits, at_end, issue, box_degen;

`ifdef SUBSAMPLE_EN
   // A zero pitch would never advance; treat it as one pixel.
   assign pitch_in = (pitch_R13U == '0) ? PIX : pitch_R13U;
`else
   logic unused_pitch;
   assign pitch_in     = PIX;
   assign unused_pitch = ^pitch_R13U;
`endif

   assign nx_x   = {cur_x[SIGFIG-1], cur_x} + $signed({1'b0, pitch_q});
   assign nx_y   = {cur_y[SIGFIG-1], cur_y} + $signed({1'b0, pitch_q});
   assign ur_xw  = {ur_x[SIGFIG-1], ur_x};
   assign ur_yw  = {ur_y[SIGFIG-1], ur_y};
   assign x_fits = (nx_x <= ur_xw);
   assign y_fits = (nx_y <= ur_yw);
   assign at_end = !x_fits && !y_fits;

   assign box_degen = (box_R13S[0][0] > box_R13S[1][0]) ||
                      (box_R13S[0][1] > box_R13S[1][1]);

   assign issue = (state == WALK) && !hold_R16H;

   assign sample_R16S[0] = cur_x;
   assign sample_R16S[1] = cur_y;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (validTri_R13H && !box_degen) state_nxt = WALK;
         WALK: if (issue && at_end)              state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      halt_R13H      = (state == WALK);
      validSamp_R16H = issue;
      last_R16H      = issue && at_end;
   end

   // Capture and raster position datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tri_R16S[v][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            color_R16U[c] <= '0;
         ll_x    <= '0;
         ur_x    <= '0;
         ur_y    <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
         pitch_q <= PIX;
      end else begin
         case (state)
            IDLE: begin
               if (validTri_R13H) begin
                  tri_R16S   <= tri_R13S;
                  color_R16U <= color_R13U;
                  ll_x       <= box_R13S[0][0];
                  ur_x       <= box_R13S[1][0];
                  ur_y       <= box_R13S[1][1];
                  pitch_q    <= pitch_in;
                  if (!box_degen) begin
                     cur_x <= box_R13S[0][0];
                     cur_y <= box_R13S[0][1];
                  end
               end
            end
            WALK: begin
               if (issue) begin
                  if (x_fits) begin
                     cur_x <= nx_x[SIGFIG-1:0];
                  end else if (y_fits) begin
                     cur_x <= ll_x;
                     cur_y <= nx_y[SIGFIG-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_sequencer.sv
// tb/tb_sample_sequencer.sv - scoreboard bench for sample_sequencer
module tb_sample_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic validTri = 1'b0;
   logic hold = 1'b0;
   logic halt, vs, last;
   logic signed [23:0] tri_in [3][3];
   logic signed [23:0] tri_out [3][3];
   logic signed [23:0] box [2][2];
   logic signed [23:0] samp [2];
   logic [23:0] col_in [3];
   logic [23:0] col_out [3];
   logic [23:0] pitch = '0;

   typedef struct {
      int x;
      int y;
      bit lst;
      int t00;
      int t22;
      int c1;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   int bx [2][4];

   sample_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .tri_R13S       (tri_in),
      .color_R13U     (col_in),
      .box_R13S       (box),
      .pitch_R13U     (pitch),
      .validTri_R13H  (validTri),
      .halt_R13H      (halt),
      .hold_R16H      (hold),
      .tri_R16S       (tri_out),
      .color_R16U     (col_out),
      .sample_R16S    (samp),
      .validSamp_R16H (vs),
      .last_R16H      (last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Present one triangle and push the samples it must produce: a W x H grid
   // enumerated by index, the final index being the last sample.
   task automatic send(input int llx, input int lly, input int urx, input int ury, input int pit);
      int p, nx, ny;
      exp_t e;
      p = 1024;
`ifdef SUBSAMPLE_EN
      p = (pit == 0) ? 1024 : pit;
`endif
      for (int a = 0; a < 3; a++) begin
         col_in[a] = 24'($urandom);
         for (int b = 0; b < 3; b++) tri_in[a][b] = 24'($urandom);
      end
      box[0][0] = 24'(llx);
      box[0][1] = 24'(lly);
      box[1][0] = 24'(urx);
      box[1][1] = 24'(ury);
      pitch = 24'(pit);
      validTri = 1'b1;
      nx = (urx >= llx) ? (urx - llx) / p + 1 : 0;
      ny = (ury >= lly) ? (ury - lly) / p + 1 : 0;
      for (int k = 0; k < nx * ny; k++) begin
         e.x   = llx + (k % nx) * p;
         e.y   = lly + (k / nx) * p;
         e.lst = (k == nx * ny - 1);
         e.t00 = int'(tri_in[0][0]);
         e.t22 = int'(tri_in[2][2]);
         e.c1  = int'(col_in[1]);
         q.push_back(e);
      end
   endtask

   // Run ncyc cycles, sending up to ntri boxes from bx whenever the DUT is idle,
   // and record per-cycle valid/halt/last bit patterns.
   task automatic run(input int ntri, input int ncyc, input int hmask, input int pit,
                      output int v, output int h, output int l);
      int sent;
      sent = 0;
      v = 0;
      h = 0;
      l = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         hold = hmask[i];
         if (sent < ntri && !halt) begin
            send(bx[sent][0], bx[sent][1], bx[sent][2], bx[sent][3], pit);
            sent++;
         end else begin
            validTri = 1'b0;
         end
         @(negedge clk);
         v[i] = vs;
         h[i] = halt;
         l[i] = last;
      end
      @(posedge clk);
      #1;
      hold = 1'b0;
      validTri = 1'b0;
   endtask

   task automatic set_box(input int n, input int a, input int b, input int c, input int d);
      bx[n][0] = a;
      bx[n][1] = b;
      bx[n][2] = c;
      bx[n][3] = d;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid_gate", vs, halt && !hold);
         chk("last_needs_valid", last && !vs, 0);
         if (vs) begin
            chk("queue_has_entry", q.size() > 0, 1);
            if (q.size() > 0) begin
               me = q.pop_front();
               chk("sample_x", samp[0], me.x);
               chk("sample_y", samp[1], me.y);
               chk("last", last, me.lst);
               chk("tri00", tri_out[0][0], me.t00);
               chk("tri22", tri_out[2][2], me.t22);
               chk("color1", col_out[1], me.c1);
            end
         end
      end
   end

   initial begin
      int v, h, l, sent, w, hh, llx, lly, urx, ury, pit, bound;
      for (int a = 0; a < 3; a++) begin
         col_in[a] = '0;
         for (int b = 0; b < 3; b++) tri_in[a][b] = '0;
         box[a % 2][a / 2] = '0;
      end
      box[1][1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_halt", halt, 0);
      chk("rst_valid", vs, 0);
      chk("rst_last", last, 0);
      chk("rst_samp_x", samp[0], 0);
      chk("rst_samp_y", samp[1], 0);
      chk("rst_tri", tri_out[0][0], 0);
      chk("rst_color", col_out[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // Two back-to-back 3x2 boxes: one bubble between them
      set_box(0, 0, 0, 2048, 1024);
      set_box(1, 0, 0, 2048, 1024);
      run(2, 15, 0, 0, v, h, l);
      chk("b2b_valid", v, 32'h3F7E);
      chk("b2b_halt", h, 32'h3F7E);
      chk("b2b_last", l, 32'h2040);
      chk("b2b_drained", q.size(), 0);

      // Hold on walk cycles 2-3
      run(1, 10, 32'hC, 0, v, h, l);
      chk("hold_valid", v, 32'h1F2);
      chk("hold_halt", h, 32'h1FE);
      chk("hold_last", l, 32'h100);
      chk("hold_drained", q.size(), 0);

      // Single-sample box
      set_box(0, 5120, 3072, 5120, 3072);
      run(1, 4, 0, 0, v, h, l);
      chk("one_valid", v, 32'h2);
      chk("one_last", l, 32'h2);
      chk("one_halt", h, 32'h2);

      // Degenerate box consumed, following triangle accepted next cycle
      set_box(0, 2048, 0, 1024, 0);
      set_box(1, 5120, 3072, 5120, 3072);
      run(2, 5, 0, 0, v, h, l);
      chk("degen_valid", v, 32'h4);
      chk("degen_halt", h, 32'h4);
      chk("degen_drained", q.size(), 0);

      // Reset after three samples of a six-sample walk
      set_box(0, 0, 0, 2048, 1024);
      run(1, 3, 0, 0, v, h, l);
      chk("pre_rst_valid", v, 32'h6);
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      chk("post_rst_valid", vs, 0);
      chk("post_rst_halt", halt, 0);
      chk("post_rst_x", samp[0], 0);
      chk("post_rst_y", samp[1], 0);
      run(1, 8, 0, 0, v, h, l);
      chk("fresh_valid", v, 32'h7E);
      chk("fresh_last", l, 32'h40);
      chk("fresh_drained", q.size(), 0);

`ifdef SUBSAMPLE_EN
      set_box(0, 0, 0, 512, 0);
      run(1, 5, 0, 256, v, h, l);
      chk("p256_valid", v, 32'hE);
      chk("p256_last", l, 32'h8);
      set_box(0, 0, 0, 1024, 0);
      run(1, 4, 0, 0, v, h, l);
      chk("p0_valid", v, 32'h6);
      chk("p0_last", l, 32'h4);
`endif

      // Randomized traffic with random hold and ignored validTri while walking
      sent = 0;
      for (int c = 0; c < 6000 && sent < 40; c++) begin
         @(posedge clk);
         #1;
         hold = ($urandom_range(0, 3) == 0);
         if (!halt) begin
            w   = $urandom_range(0, 3);
            hh  = $urandom_range(0, 3);
            pit = $urandom_range(0, 4) * 256;
            if ($urandom_range(0, 7) == 0) begin
               urx = 8388608 - 1024;
               ury = 8388608 - 1024;
               llx = urx - w * 1024;
               lly = ury - hh * 1024;
            end else begin
               llx = (int'($urandom_range(0, 16)) - 8) * 1024;
               lly = (int'($urandom_range(0, 16)) - 8) * 1024;
               urx = llx + w * 1024;
               ury = lly + hh * 1024;
            end
            if ($urandom_range(0, 9) == 0) urx = llx - 1024;
            send(llx, lly, urx, ury, pit);
            sent++;
         end else begin
            validTri = ($urandom_range(0, 3) == 0);
         end
      end
      @(posedge clk);
      #1;
      validTri = 1'b0;
      hold = 1'b0;
      bound = 0;
      while (q.size() > 0 && bound < 400) begin
         @(posedge clk);
         bound++;
      end
      repeat (2) @(posedge clk);
      chk("rand_all_sent", sent, 40);
      chk("rand_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
